// File: rtl/fifo_access_if.sv
// fifo_access_if: micro-op, channel FIFO and register-file signals of the FIFO access engine
interface fifo_access_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5
);
  logic                     op_valid;
  logic                     op_ready;
  logic                     op_load;
  logic                     op_store;
  logic [CH_W-1:0]          op_ch;
  logic [RF_AW-1:0]         op_wraddr;
  logic [DATA_W-1:0]        op_wdata;
  logic [NUM_CH-1:0]        req_fifo_empty;
  logic [NUM_CH*DATA_W-1:0] req_fifo_rdata;
  logic [NUM_CH-1:0]        req_fifo_deq;
  logic [NUM_CH-1:0]        read_fifo_wrfull;
  logic [NUM_CH-1:0]        read_fifo_enq;
  logic [DATA_W-1:0]        read_fifo_wdata;
  logic                     regfile_wren;
  logic [RF_AW-1:0]         regfile_wraddr;
  logic [DATA_W-1:0]        regfile_wdata;
  logic                     busy;
  logic                     done;
  logic                     timeout;
  logic                     err;
  modport master (
    output op_valid, op_load, op_store, op_ch, op_wraddr, op_wdata,
           req_fifo_empty, req_fifo_rdata, read_fifo_wrfull,
    input  op_ready, req_fifo_deq, read_fifo_enq, read_fifo_wdata,
           regfile_wren, regfile_wraddr, regfile_wdata, busy, done, timeout, err
  );
  modport slave (
    input  op_valid, op_load, op_store, op_ch, op_wraddr, op_wdata,
           req_fifo_empty, req_fifo_rdata, read_fifo_wrfull,
    output op_ready, req_fifo_deq, read_fifo_enq, read_fifo_wdata,
           regfile_wren, regfile_wraddr, regfile_wdata, busy, done, timeout, err
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: stalling multi-channel LOAD_FIFO/STORE_FIFO engine with optional wait timeout
module fifo_access_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 16
) (
  input logic clk,
  input logic rst,
  fifo_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
  state_t            state;
  logic              is_load;
  logic [CH_W-1:0]   ch;
  logic [RF_AW-1:0]  wraddr, held_wraddr;
  logic [DATA_W-1:0] wdata, held_rf_wdata, held_fifo_wdata, head;
  logic [TO_W-1:0]   wait_cnt;
  logic [NUM_CH-1:0] sel;
  logic              ch_ready, go, expire, legal, illegal;
  always_comb begin
    sel  = '0;
    head = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == CH_W'(i)) begin
        sel[i] = 1'b1;
        head   = bus.req_fifo_rdata[i*DATA_W +: DATA_W];
      end
  end
  assign ch_ready = is_load ? |(sel & ~bus.req_fifo_empty) : |(sel & ~bus.read_fifo_wrfull);
  // rst suppresses every pulse in its own cycle so an aborted op leaves no trace
  assign go      = state == ACCESS && !rst && ch_ready;
  assign expire  = state == ACCESS && !rst && !ch_ready && TIMEOUT != 0 && wait_cnt == TO_W'(TIMEOUT - 1);
  assign legal   = (bus.op_load ^ bus.op_store) && 32'(bus.op_ch) < NUM_CH;
  assign illegal = (bus.op_load && bus.op_store) || 32'(bus.op_ch) >= NUM_CH;
  assign bus.op_ready        = state == IDLE;
  assign bus.busy            = state != IDLE;
  assign bus.err             = state == ERR;
  assign bus.done            = go;
  assign bus.timeout         = expire;
  assign bus.req_fifo_deq    = (go && is_load) ? sel : '0;
  assign bus.read_fifo_enq   = (go && !is_load) ? sel : '0;
  assign bus.regfile_wren    = go && is_load;
  assign bus.regfile_wraddr  = (go && is_load) ? wraddr : held_wraddr;
  assign bus.regfile_wdata   = (go && is_load) ? head : held_rf_wdata;
  assign bus.read_fifo_wdata = (go && !is_load) ? wdata : held_fifo_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      is_load         <= 1'b0;
      ch              <= '0;
      wraddr          <= '0;
      wdata           <= '0;
      wait_cnt        <= '0;
      held_wraddr     <= '0;
      held_rf_wdata   <= '0;
      held_fifo_wdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.op_valid && legal) begin
            state    <= ACCESS;
            is_load  <= bus.op_load;
            ch       <= bus.op_ch;
            wraddr   <= bus.op_wraddr;
            wdata    <= bus.op_wdata;
            wait_cnt <= '0;
          end else if (bus.op_valid && illegal) state <= ERR;
        ACCESS:
          if (go) begin
            state <= IDLE;
            if (is_load) begin
              held_wraddr   <= wraddr;
              held_rf_wdata <= head;
            end else held_fifo_wdata <= wdata;
          end else if (expire) state <= IDLE;
          else wait_cnt <= (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb_fifo_access_ctrl: directed plus randomized ops checked against a per-op outcome model
module tb_fifo_access_ctrl;
  localparam int NUM_CH = 4, CH_W = 3, DATA_W = 8, RF_AW = 4, TIMEOUT = 16, RW = NUM_CH * DATA_W;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fifo_access_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .RF_AW(RF_AW)) bus ();
  fifo_access_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .RF_AW(RF_AW),
                     .TIMEOUT(TIMEOUT), .TO_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  logic [RF_AW-1:0]  m_wraddr = '0;
  logic [DATA_W-1:0] m_rfdata = '0, m_fdata = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 0);
    chk({tag, "_deq"}, 32'(bus.req_fifo_deq), 0);
    chk({tag, "_enq"}, 32'(bus.read_fifo_enq), 0);
    chk({tag, "_wren"}, 32'(bus.regfile_wren), 0);
    chk({tag, "_wraddr"}, 32'(bus.regfile_wraddr), 32'(m_wraddr));
    chk({tag, "_rfdata"}, 32'(bus.regfile_wdata), 32'(m_rfdata));
    chk({tag, "_fdata"}, 32'(bus.read_fifo_wdata), 32'(m_fdata));
  endtask
  task automatic drive_status(input int ch, input bit ld, input bit blk, input logic [DATA_W-1:0] head);
    bus.req_fifo_empty   = NUM_CH'($urandom);
    bus.read_fifo_wrfull = NUM_CH'($urandom);
    bus.req_fifo_rdata   = RW'($urandom);
    if (ch < NUM_CH) begin
      if (ld) bus.req_fifo_empty[ch] = blk;
      else bus.read_fifo_wrfull[ch] = blk;
      bus.req_fifo_rdata[ch*DATA_W +: DATA_W] = head;
    end
  endtask
  task automatic run_op(input bit ld, input bit st, input int ch, input logic [RF_AW-1:0] wa,
                        input logic [DATA_W-1:0] wd, input int block, input logic [DATA_W-1:0] head);
    logic [NUM_CH-1:0] oh;
    bit fin, to;
    oh = (ch < NUM_CH) ? NUM_CH'(1) << ch : '0;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_load = ld; bus.op_store = st;
    bus.op_ch = CH_W'(ch); bus.op_wraddr = wa; bus.op_wdata = wd;
    drive_status(ch, ld, 1'b1, head);
    #1;
    chk("accept_ready", 32'(bus.op_ready), 1);
    chk("accept_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_load = 1'($urandom); bus.op_store = 1'($urandom);
    bus.op_ch = CH_W'($urandom); bus.op_wraddr = RF_AW'($urandom); bus.op_wdata = DATA_W'($urandom);
    if (ld == st || ch >= NUM_CH) begin
      drive_status(ch, ld, 1'b0, head);
      #1;
      if ((ld && st) || ch >= NUM_CH) begin
        chk("err_pulse", 32'(bus.err), 1);
        chk("err_busy", 32'(bus.busy), 1);
        chk("err_ready", 32'(bus.op_ready), 0);
      end else begin
        chk("ignore_err", 32'(bus.err), 0);
        chk("ignore_busy", 32'(bus.busy), 0);
        chk("ignore_ready", 32'(bus.op_ready), 1);
      end
      chk_quiet("rejected");
      @(posedge clk); #2;
      chk("after_reject_ready", 32'(bus.op_ready), 1);
      chk("after_reject_err", 32'(bus.err), 0);
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      drive_status(ch, ld, k <= block, head);
      #1;
      fin = (k == block + 1);
      to  = !fin && k == TIMEOUT;
      if (fin) begin
        if (ld) begin m_wraddr = wa; m_rfdata = head; end
        else m_fdata = wd;
      end
      chk("acc_busy", 32'(bus.busy), 1);
      chk("acc_ready", 32'(bus.op_ready), 0);
      chk("acc_err", 32'(bus.err), 0);
      chk("acc_done", 32'(bus.done), 32'(fin));
      chk("acc_timeout", 32'(bus.timeout), 32'(to));
      chk("acc_deq", 32'(bus.req_fifo_deq), (fin && ld) ? 32'(oh) : 0);
      chk("acc_enq", 32'(bus.read_fifo_enq), (fin && !ld) ? 32'(oh) : 0);
      chk("acc_wren", 32'(bus.regfile_wren), 32'(fin && ld));
      chk("acc_wraddr", 32'(bus.regfile_wraddr), 32'(m_wraddr));
      chk("acc_rfdata", 32'(bus.regfile_wdata), 32'(m_rfdata));
      chk("acc_fdata", 32'(bus.read_fifo_wdata), 32'(m_fdata));
      if (fin || to) break;
    end
    @(posedge clk); #1;
    drive_status(ch, ld, 1'b0, DATA_W'($urandom));
    #1;
    chk("post_ready", 32'(bus.op_ready), 1);
    chk("post_busy", 32'(bus.busy), 0);
    chk_quiet("post");
  endtask
  initial begin
    bus.op_valid = 1'b0; bus.op_load = 1'b0; bus.op_store = 1'b0; bus.op_ch = '0;
    bus.op_wraddr = '0; bus.op_wdata = '0;
    drive_status(0, 1'b1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", 32'(bus.op_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk_quiet("rst");
    rst = 1'b0;
    run_op(1, 0, 2, 4'd3, 8'h00, 0, 8'hA5);
    chk("load_ch2_wdata", 32'(m_rfdata), 32'hA5);
    run_op(0, 1, 1, 4'd0, 8'h3C, 5, 8'h11);
    run_op(1, 0, 0, 4'd7, 8'h00, 1000, 8'h22);
    run_op(1, 0, 0, 4'd9, 8'h00, TIMEOUT - 1, 8'h5A);
    run_op(1, 1, 1, 4'd2, 8'h44, 0, 8'h33);
    run_op(1, 0, 5, 4'd2, 8'h44, 0, 8'h33);
    run_op(0, 0, 2, 4'd2, 8'h44, 0, 8'h33);
    // abort a blocked store with rst on its 3rd ACCESS cycle, channel unblocking at the same time
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_load = 1'b0; bus.op_store = 1'b1; bus.op_ch = 3'd3; bus.op_wdata = 8'h77;
    drive_status(3, 1'b0, 1'b1, '0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      if (k == 3) rst = 1'b1;
      drive_status(3, 1'b0, k < 3, '0);
      #1;
      chk("abort_enq", 32'(bus.read_fifo_enq), 0);
      chk("abort_done", 32'(bus.done), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_wraddr = '0; m_rfdata = '0; m_fdata = '0;
    for (int k = 0; k < 3; k++) begin
      drive_status(3, 1'b0, 1'b0, '0);
      #1;
      chk("abort_post_ready", 32'(bus.op_ready), 1);
      chk("abort_post_busy", 32'(bus.busy), 0);
      chk_quiet("abort_post");
      @(posedge clk); #1;
    end
    for (int n = 0; n < 60; n++) begin
      int kind, blk;
      bit ld;
      kind = $urandom_range(0, 9);
      ld = 1'($urandom);
      blk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
      case (kind)
        0: run_op(1, 1, $urandom_range(0, 3), RF_AW'($urandom), DATA_W'($urandom), blk, DATA_W'($urandom));
        1: run_op(ld, !ld, $urandom_range(4, 7), RF_AW'($urandom), DATA_W'($urandom), blk, DATA_W'($urandom));
        2: run_op(0, 0, $urandom_range(0, 3), RF_AW'($urandom), DATA_W'($urandom), blk, DATA_W'($urandom));
        default: run_op(ld, !ld, $urandom_range(0, 3), RF_AW'($urandom), DATA_W'($urandom), blk, DATA_W'($urandom));
      endcase
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
